// File: rtl/norm_stage_if.sv
// Handshake and data bundle between the accumulator, norm_stage and the packing stage.
// The slave modport is the norm_stage view; master is the driving (upstream/downstream) side.
interface norm_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_pre;
  logic [67:0] in_mant;
  logic [19:0] in_exp;
  logic [3:0]  in_s;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_pre;
  logic [67:0] mant;
  logic [19:0] exp;
  logic [3:0]  s;

  modport slave (
    input  in_valid, in_pre, in_mant, in_exp, in_s, out_ready,
    output in_ready, out_valid, out_pre, mant, exp, s
  );

  modport master (
    output in_valid, in_pre, in_mant, in_exp, in_s, out_ready,
    input  in_ready, out_valid, out_pre, mant, exp, s
  );
endinterface

// File: rtl/norm_stage.sv
// Two-stage per-lane mantissa normalizer (4x17 / 2x34 / 1x68 lanes) with valid/ready flow control.
// Define NORM_EXP_SAT_EN to clamp the adjusted exponent at its field minimum instead of wrapping.
module norm_stage (
  input logic       clk,
  input logic       rst,
  norm_stage_if.slave bus
);
  typedef enum logic [1:0] {
    PRE_8   = 2'b00,
    PRE_16  = 2'b01,
    PRE_32  = 2'b10,
    PRE_BAD = 2'b11
  } pre_e;

  logic             v1;
  logic             adv1;
  logic             adv2;
  pre_e             pre1;
  logic [67:0]      mant1;
  logic [19:0]      exp1;
  logic [3:0]       s1;
  logic [3:0][4:0]  sh8_d,  sh8_q;
  logic [1:0][5:0]  sh16_d, sh16_q;
  logic [6:0]       sh32_d, sh32_q;
  logic [67:0]      mant_d;
  logic [19:0]      exp_d;

  // Shift that brings the top set bit of lane[w-2:0] up to bit w-2; zero for carry or empty lanes.
  function automatic logic [6:0] norm_shift(input logic [67:0] v, input int unsigned w);
    logic [6:0] k;
    k = '0;
    if (!v[w-1]) begin
      for (int unsigned i = 0; i < 67; i++) begin
        if ((i + 2 <= w) && v[i]) k = 7'(w - 2 - i);
      end
    end
    return k;
  endfunction

  function automatic logic [19:0] adj_exp(input logic [19:0] e, input logic [6:0] k,
                                          input int unsigned f);
    logic signed [21:0] ext;
    logic signed [21:0] d;
    for (int unsigned i = 0; i < 22; i++) ext[i] = (i < f) ? e[i] : e[f-1];
    d = ext - $signed({15'b0, k});
`ifdef NORM_EXP_SAT_EN
    if (d < -(22'sd1 <<< (f - 1))) d = -(22'sd1 <<< (f - 1));
`endif
    return d[19:0];
  endfunction

  assign adv2         = v1 && (!bus.out_valid || bus.out_ready);
  assign bus.in_ready = !rst && (!v1 || adv2);
  assign adv1         = bus.in_valid && bus.in_ready;

  // All three lane splittings are evaluated; stage 2 picks the one matching the precision.
  always_comb begin
    sh8_d  = '0;
    sh16_d = '0;
    for (int unsigned i = 0; i < 4; i++)
      sh8_d[i] = 5'(norm_shift({51'b0, bus.in_mant[17*i +: 17]}, 17));
    for (int unsigned j = 0; j < 2; j++)
      sh16_d[j] = 6'(norm_shift({34'b0, bus.in_mant[34*j +: 34]}, 34));
    sh32_d = norm_shift(bus.in_mant, 68);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
    end else if (adv1) begin
      v1 <= 1'b1;
    end else if (adv2) begin
      v1 <= 1'b0;
    end
    if (adv1) begin
      pre1   <= pre_e'(bus.in_pre);
      mant1  <= bus.in_mant;
      exp1   <= bus.in_exp;
      s1     <= bus.in_s;
      sh8_q  <= sh8_d;
      sh16_q <= sh16_d;
      sh32_q <= sh32_d;
    end
  end

  always_comb begin
    mant_d = '0;
    exp_d  = '0;
    case (pre1)
      PRE_8: begin
        for (int unsigned i = 0; i < 4; i++) begin
          mant_d[17*i +: 17] = mant1[17*i +: 17] << sh8_q[i];
          exp_d[5*i +: 5]    = 5'(adj_exp({15'b0, exp1[5*i +: 5]}, {2'b0, sh8_q[i]}, 5));
        end
      end
      PRE_16: begin
        for (int unsigned j = 0; j < 2; j++) begin
          mant_d[34*j +: 34] = mant1[34*j +: 34] << sh16_q[j];
          exp_d[10*j +: 10]  = 10'(adj_exp({10'b0, exp1[10*j +: 10]}, {1'b0, sh16_q[j]}, 10));
        end
      end
      PRE_32: begin
        mant_d = mant1 << sh32_q;
        exp_d  = adj_exp(exp1, sh32_q, 20);
      end
      default: begin
        mant_d = '0;
        exp_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_pre   <= '0;
      bus.mant      <= '0;
      bus.exp       <= '0;
      bus.s         <= '0;
    end else if (adv2) begin
      bus.out_valid <= 1'b1;
      bus.out_pre   <= pre1;
      bus.mant      <= mant_d;
      bus.exp       <= exp_d;
      bus.s         <= (pre1 == PRE_BAD) ? 4'b0 : s1;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_norm_stage.sv
// Bench for norm_stage: vector table through a scoreboard plus latency, stall and reset sequences.
module tb_norm_stage;
`ifdef NORM_EXP_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  norm_stage_if bus();
  norm_stage dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [1:0]  pre;
    logic [67:0] mant;
    logic [19:0] exp;
    logic [3:0]  s;
  } beat_t;

  typedef struct {
    beat_t in;
    beat_t out;
  } vec_t;

  vec_t        vecs[10];
  beat_t       sb[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [67:0] got, input logic [67:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] pre, input logic [67:0] m, input logic [19:0] e,
                              input logic [3:0] s, input logic [67:0] om, input logic [19:0] oe);
    vec_t v;
    v.in.pre  = pre;  v.in.mant  = m;  v.in.exp  = e;  v.in.s  = s;
    v.out.pre = pre;  v.out.mant = om; v.out.exp = oe;
    v.out.s   = (pre == 2'b11) ? 4'b0 : s;
    return v;
  endfunction

  always @(negedge clk) begin : monitor
    beat_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got mant %0h exp %0h, expected no output", bus.mant, bus.exp);
      end else begin
        e = sb.pop_front();
        chk("out_pre", {66'b0, bus.out_pre}, {66'b0, e.pre});
        chk("out_mant", bus.mant, e.mant);
        chk("out_exp", {48'b0, bus.exp}, {48'b0, e.exp});
        chk("out_s", {64'b0, bus.s}, {64'b0, e.s});
      end
    end
  end

  task automatic drive(input vec_t v, output int unsigned waits);
    waits = 0;
    bus.in_valid = 1'b1;
    bus.in_pre   = v.in.pre;
    bus.in_mant  = v.in.mant;
    bus.in_exp   = v.in.exp;
    bus.in_s     = v.in.s;
    @(negedge clk);
    while (!bus.in_ready && waits < 40) begin
      waits++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected 1", waits);
    end else begin
      sb.push_back(v.out);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("drain_pending", 68'(sb.size()), 68'd0);
    @(posedge clk);
    #1;
  endtask

  // Expects an empty pipeline and an input just accepted at the previous edge.
  task automatic check_latency(input string tag);
    @(negedge clk);
    chk({tag, "_valid_c1"}, {67'b0, bus.out_valid}, 68'd0);
    @(negedge clk);
    chk({tag, "_valid_c2"}, {67'b0, bus.out_valid}, 68'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    int unsigned w;
    int unsigned t0;
    logic [67:0] held_mant;
    logic [19:0] held_exp;

    vecs[0] = mk(2'b00, {17'h0, 17'h0C000, 17'h10000, 17'h00010}, {5'h1F, 5'h0A, 5'h05, 5'h03}, 4'b1010,
                 {17'h0, 17'h0C000, 17'h10000, 17'h08000}, {5'h1F, 5'h0A, 5'h05, 5'h18});
    vecs[1] = mk(2'b00, {17'h01234, 17'h04000, 17'h00003, 17'h00001}, {5'h02, 5'h0F, 5'h00, 5'h16}, 4'b0101,
                 {17'h091A0, 17'h08000, 17'h0C000, 17'h08000},
                 {5'h1F, 5'h0E, 5'h12, (SAT ? 5'h10 : 5'h07)});
    vecs[2] = mk(2'b10, 68'h1, 20'h0, 4'b1111, 68'h40000000000000000, 20'hFFFBE);
    vecs[3] = mk(2'b01, {34'h200000001, 34'h000000100}, {10'h155, 10'h005}, 4'b0011,
                 {34'h200000001, 34'h100000000}, {10'h155, 10'h3ED});
    vecs[4] = mk(2'b10, 68'h1, 20'h80010, 4'b0000, 68'h40000000000000000,
                 (SAT ? 20'h80000 : 20'h7FFCE));
    vecs[5] = mk(2'b11, 68'hFFFFFFFFFFFFFFFFF, 20'hFFFFF, 4'hF, 68'h0, 20'h0);
    vecs[6] = mk(2'b01, {34'h000000001, 34'h0}, {10'h200, 10'h3FF}, 4'b1000,
                 {34'h100000000, 34'h0}, {(SAT ? 10'h200 : 10'h1E0), 10'h3FF});
    vecs[7] = mk(2'b00, 68'h0, 20'hABCDE, 4'b0110, 68'h0, 20'hABCDE);
    vecs[8] = mk(2'b10, 68'h40000000000000005, 20'h12345, 4'b1001, 68'h40000000000000005, 20'h12345);
    vecs[9] = mk(2'b10, 68'h100000000, 20'h00022, 4'b0100, 68'h40000000000000000, 20'h00000);

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_pre    = '0;
    bus.in_mant   = '0;
    bus.in_exp    = '0;
    bus.in_s      = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready", {67'b0, bus.in_ready}, 68'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", {67'b0, bus.out_valid}, 68'd0);
    chk("rst_mant", bus.mant, 68'd0);
    chk("rst_exp", {48'b0, bus.exp}, 68'd0);
    chk("rst_s", {64'b0, bus.s}, 68'd0);
    chk("rst_out_pre", {66'b0, bus.out_pre}, 68'd0);

    // pre=11 through an empty pipe: first-cycle acceptance and two-cycle latency
    drive(vecs[5], w);
    bus.in_valid = 1'b0;
    chk("accept_first_cycle", 68'(w), 68'd0);
    check_latency("lat_pre11");
    drain();

    // Full table back to back: one acceptance per cycle
    t0 = cyc;
    for (int i = 0; i < 10; i++) drive(vecs[i], w);
    bus.in_valid = 1'b0;
    chk("throughput_cycles", 68'(cyc - t0), 68'd10);
    drain();

    // Backpressure: two accepted, third held off, outputs frozen
    bus.out_ready = 1'b0;
    drive(vecs[0], w);
    drive(vecs[1], w);
    fork
      drive(vecs[2], w);
      begin
        @(negedge clk);
        chk("stall_in_ready", {67'b0, bus.in_ready}, 68'd0);
        held_mant = bus.mant;
        held_exp  = bus.exp;
        chk("stall_head_mant", held_mant, vecs[0].out.mant);
        repeat (4) begin
          @(negedge clk);
          chk("stall_valid", {67'b0, bus.out_valid}, 68'd1);
          chk("stall_mant", bus.mant, held_mant);
          chk("stall_exp", {48'b0, bus.exp}, {48'b0, held_exp});
          chk("stall_in_ready_hold", {67'b0, bus.in_ready}, 68'd0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    bus.in_valid = 1'b0;
    drain();

    // Reset with two results in flight: both discarded, pipe restarts cleanly
    bus.out_ready = 1'b0;
    drive(vecs[3], w);
    drive(vecs[4], w);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("midrst_in_ready", {67'b0, bus.in_ready}, 68'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    chk("midrst_out_valid", {67'b0, bus.out_valid}, 68'd0);
    drive(vecs[6], w);
    bus.in_valid = 1'b0;
    chk("midrst_accept_first", 68'(w), 68'd0);
    check_latency("lat_after_rst");
    drain();
    repeat (5) @(posedge clk);
    #1;
    chk("final_scoreboard_empty", 68'(sb.size()), 68'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule

// File: doc/norm_stage.md
NORM_STAGE -- requirements
Module: norm_stage

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: in_valid  input  1  upstream accumulator result valid.
REQ-004 SHALL have ports: in_ready  output  1  stage can accept a result this cycle.
REQ-005 SHALL have ports: in_pre  input  2  precision: 00=4x8-bit, 01=2x16-bit, 10=1x32-bit, 11=invalid.
REQ-006 SHALL have ports: in_mant  input  68  raw per-lane mantissas, lane widths 17/34/68.
REQ-007 SHALL have ports: in_exp  input  20  per-lane two's-complement scale, field widths 5/10/20.
REQ-008 SHALL have ports: in_s  input  4  per-lane sign, passed through unchanged.
REQ-009 SHALL have ports: out_valid  output  1, out_ready  input  1  downstream handshake to packing.
REQ-010 SHALL have ports: out_pre  output  2, mant  output  68, exp  output  20, s  output  4  normalized result.

Function
REQ-011 SHALL transfer on a port when valid and ready are both high at a rising edge.
REQ-012 SHALL be a 2-stage pipeline: stage 1 registers per-lane leading-zero counts plus inputs; stage 2 registers shifted mantissa and adjusted exponent.
REQ-013 SHALL give a latency of exactly 2 cycles from input transfer to out_valid when out_ready stays high.
REQ-014 SHALL sustain one transfer per cycle when out_ready stays high.
REQ-015 SHALL advance each stage only when the next register is empty or is being drained the same cycle; in_ready = !v1 | advance1, combinational from out_ready.
REQ-016 SHALL hold out_valid and all output data stable while out_valid=1 and out_ready=0.
REQ-017 SHALL use lane layout: pre=00 lane i mant[17i+16:17i], exp[5i+4:5i]; pre=01 lane j mant[34j+33:34j], exp[10j+9:10j]; pre=10 mant[67:0], exp[19:0].
REQ-018 SHALL, per lane of width W, leave the lane unchanged with shift 0 if bit W-1 is set (carry case) or the lane is all zero.
REQ-019 SHALL otherwise use k = leading-zero count of lane[W-2:0], output lane<<k, and exp = exp-k in the lane's field width.
REQ-020 SHALL guarantee the result lane has bit W-1 or bit W-2 set, or is zero.
REQ-021 SHALL, for pre=11, pass out_pre=11 with mant, exp and s forced to 0, still honouring the handshake.
REQ-022 SHALL pass s and in_pre through aligned with their data.

Reset
REQ-023 SHALL, when rst is high at a rising edge, clear both stage valids and set out_valid=0, mant=0, exp=0, s=0, out_pre=00.
REQ-024 SHALL drive in_ready=0 in the cycle rst is high.
REQ-025 SHALL discard in-flight results on reset mid-operation and never emit them afterwards.
REQ-026 SHALL accept input in the first cycle after rst deasserts.

Configuration
REQ-027 SHALL, when NORM_EXP_SAT_EN is defined, clamp exp-k below the field minimum (-16, -512, -524288) to that minimum.
REQ-028 SHALL, when NORM_EXP_SAT_EN is undefined, let exp-k wrap modulo 2^fieldwidth.

Verification
REQ-029 SHALL cover: pre=00, lane0 mant=17'h00010, exp=5'h03 -> lane0 mant=17'h08000, exp=5'h18 (-8) after 2 cycles.
REQ-030 SHALL cover: pre=00, lane0 mant=17'h00001, exp=5'h16 (-10) -> mant=17'h08000; exp=5'h10 with NORM_EXP_SAT_EN, 5'h07 without.
REQ-031 SHALL cover: pre=10, mant=68'h1, exp=0 -> mant bit 66 only, exp=20'hFFFBE (-66); pre=01 lane1 bit 33 set -> lane unchanged, exp unchanged.
REQ-032 SHALL cover: three back-to-back inputs with out_ready=0 for 4 cycles -> in_ready=0 after 2 accepted, outputs stable; release -> results in order, no loss or duplication.
REQ-033 SHALL cover: rst pulsed while two results are in flight -> out_valid=0 next cycle, neither result appears; next input emerges 2 cycles after acceptance.
REQ-034 SHALL cover: pre=11 with nonzero inputs -> out_pre=11, mant=0, exp=0, s=0, out_valid asserted after 2 cycles.
